// File: rtl/pingpong_window_linebuffer.sv
// pingpong_window_linebuffer: two-bank line store that presents a KW-tap
// horizontal window per column, right edge replicated.
module pingpong_window_linebuffer #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 512,
  parameter int KW     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_data_valid,
  output logic                 o_wr_ready,
  output logic                 o_overflow,
  input  logic                 i_rd_data,
  output logic                 o_line_ready,
  output logic [KW*DATA_W-1:0] o_data,
  output logic                 o_data_valid
);

  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  logic [DATA_W-1:0]    mem_q [2][LINE_W];
  logic [1:0]           st_q [2];
  logic [1:0]           st_d [2];
  logic [CW-1:0]        wr_col_q, wr_col_d;
  logic [CW-1:0]        rd_col_q, rd_col_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 wr_rdy_q, wr_rdy_d;
  logic                 ln_rdy_q, ln_rdy_d;
  logic                 ovf_q;
  logic [KW*DATA_W-1:0] data_q;
  logic                 valid_q;
  logic [KW*DATA_W-1:0] win;
  logic                 wr_acc;
  logic                 rd_acc;

  assign wr_acc = i_data_valid && wr_rdy_q;
  assign rd_acc = i_rd_data && ln_rdy_q;

  always_comb begin
    st_d      = st_q;
    wr_col_d  = wr_col_q;
    rd_col_d  = rd_col_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_acc) begin
      if (wr_col_q == COL_LAST) begin
        st_d[wr_bank_q] = FULL;
        wr_bank_d       = ~wr_bank_q;
        wr_col_d        = '0;
      end else begin
        st_d[wr_bank_q] = FILLING;
        wr_col_d        = wr_col_q + 1'b1;
      end
    end
    // A read can only target the FULL bank, so it never collides with
    // the write above.
    if (rd_acc) begin
      if (rd_col_q == COL_LAST) begin
        st_d[rd_bank_q] = EMPTY;
        rd_bank_d       = ~rd_bank_q;
        rd_col_d        = '0;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
    wr_rdy_d = (st_d[wr_bank_d] != FULL);
    ln_rdy_d = (st_d[rd_bank_d] == FULL);
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < KW; k++) begin
      int            c;
      logic [CW-1:0] idx;
      c = int'(rd_col_q) + k;
      if (c > LINE_W - 1) c = LINE_W - 1;
      idx = c[CW-1:0];
      win[(KW-1-k)*DATA_W +: DATA_W] = mem_q[rd_bank_q][idx];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wr_col_q  <= '0;
      rd_col_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_rdy_q  <= 1'b1;
      ln_rdy_q  <= 1'b0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_col_q  <= wr_col_d;
      rd_col_q  <= rd_col_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_rdy_q  <= wr_rdy_d;
      ln_rdy_q  <= ln_rdy_d;
      ovf_q     <= i_data_valid && !wr_rdy_q;
      valid_q   <= rd_acc;
      if (rd_acc) data_q <= win;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_bank_q][wr_col_q] <= i_data;
  end

  assign o_wr_ready   = wr_rdy_q;
  assign o_line_ready = ln_rdy_q;
  assign o_overflow   = ovf_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;

endmodule
